draw_hook_param: RTL

Parametrised successor to the fixed-angle hook drawer. On a start pulse it draws the rope as a Bresenham line from a fixed pivot to a caller-supplied tip point, then draws the hook as a midpoint circle around the tip with a per-octant enable mask. It emits one pixel per accepted cycle to the VGA framebuffer writer, honours backpressure, clips to the screen and supports an erase mode. It sits between the game-state logic and the framebuffer write port.

---
 rtl/draw_hook_param.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/draw_hook_param.sv
// Draws a Bresenham rope from a fixed pivot to a caller-supplied tip, then a
// midpoint-circle hook around the tip with per-octant enables, one pixel per accepted cycle.
module draw_hook_param #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 12,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int START_X  = 160,
  parameter int START_Y  = 45,
  parameter int RADIUS   = 20,
  parameter logic [COLOR_W-1:0] ROPE_COLOR = 12'hBBB,
  parameter logic [COLOR_W-1:0] HOOK_COLOR = 12'hBBB,
  parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     tip_x,
  input  logic [Y_W-1:0]     tip_y,
  input  logic [7:0]         arc_mask,
  input  logic               erase,
  input  logic               pixel_ready,
  output logic [X_W-1:0]     outX,
  output logic [Y_W-1:0]     outY,
  output logic [COLOR_W-1:0] color,
  output logic               writeEn,
  output logic               busy,
  output logic               done
);
  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 4;
  typedef logic signed [CW-1:0] coord_t;

  localparam coord_t PIV_X = coord_t'(START_X);
  localparam coord_t PIV_Y = coord_t'(START_Y);
  localparam coord_t SCR_W = coord_t'(SCREEN_W);
  localparam coord_t SCR_H = coord_t'(SCREEN_H);
  localparam coord_t RAD   = coord_t'(RADIUS);
  localparam coord_t D0    = coord_t'(1 - RADIUS);
  localparam coord_t ONE   = coord_t'(1);
  localparam coord_t THREE = coord_t'(3);
  localparam coord_t FIVE  = coord_t'(5);

  typedef enum logic [2:0] {IDLE, LINE, ARC_INIT, ARC, DONE} state_t;

  state_t state_reg, state_next;
  coord_t tx_reg, tx_next, ty_reg, ty_next;
  logic [7:0] mask_reg, mask_next;
  logic erase_reg, erase_next;
  coord_t lx_reg, lx_next, ly_reg, ly_next;
  coord_t dx_reg, dx_next, dy_reg, dy_next, err_reg, err_next;
  coord_t sx_reg, sx_next, sy_reg, sy_next;
  coord_t ax_reg, ax_next, ay_reg, ay_next, d_reg, d_next;
  logic [2:0] slot_reg, slot_next;
  logic [X_W-1:0] out_x_reg, out_x_next;
  logic [Y_W-1:0] out_y_reg, out_y_next;
  logic [COLOR_W-1:0] color_reg, color_next;
  logic we_reg, we_next, busy_reg, busy_next, done_reg, done_next;

  coord_t pt_x, pt_y, e2, diff_x, diff_y;
  logic [COLOR_W-1:0] pt_col;
  logic pt_valid, pt_en, use_arc, advance;
  logic [2*CW-1:0] arc_pt;

  function automatic logic [2*CW-1:0] arc_point(input logic [2:0] k, input coord_t x,
                                                input coord_t y, input coord_t cx, input coord_t cy);
    coord_t px, py;
    case (k)
      3'd0:    begin px = cx + x; py = cy + y; end
      3'd1:    begin px = cx + y; py = cy + x; end
      3'd2:    begin px = cx + y; py = cy - x; end
      3'd3:    begin px = cx + x; py = cy - y; end
      3'd4:    begin px = cx - x; py = cy - y; end
      3'd5:    begin px = cx - y; py = cy - x; end
      3'd6:    begin px = cx - y; py = cy + x; end
      default: begin px = cx - x; py = cy + y; end
    endcase
    return {px, py};
  endfunction

  function automatic logic on_screen(input coord_t px, input coord_t py);
    return !px[CW-1] && (px < SCR_W) && !py[CW-1] && (py < SCR_H);
  endfunction

  // A masked or clipped pixel never waits on the framebuffer.
  assign advance = !we_reg || pixel_ready;

  always_comb begin
    state_next = state_reg;
    tx_next = tx_reg; ty_next = ty_reg; mask_next = mask_reg; erase_next = erase_reg;
    lx_next = lx_reg; ly_next = ly_reg; dx_next = dx_reg; dy_next = dy_reg;
    err_next = err_reg; sx_next = sx_reg; sy_next = sy_reg;
    ax_next = ax_reg; ay_next = ay_reg; d_next = d_reg; slot_next = slot_reg;
    busy_next = busy_reg; done_next = 1'b0;
    pt_valid = 1'b0; pt_en = 1'b0; use_arc = 1'b0;
    pt_x = PIV_X; pt_y = PIV_Y; pt_col = color_reg;
    e2 = err_reg <<< 1; diff_x = '0; diff_y = '0; arc_pt = '0;
    case (state_reg)
      IDLE: if (start) begin
        tx_next = coord_t'(tip_x);
        ty_next = coord_t'(tip_y);
        mask_next = arc_mask;
        erase_next = erase;
        diff_x = tx_next - PIV_X;
        diff_y = ty_next - PIV_Y;
        dx_next = diff_x[CW-1] ? -diff_x : diff_x;
        dy_next = diff_y[CW-1] ? diff_y : -diff_y;
        err_next = dx_next + dy_next;
        sx_next = diff_x[CW-1] ? -ONE : ONE;
        sy_next = diff_y[CW-1] ? -ONE : ONE;
        lx_next = PIV_X; ly_next = PIV_Y;
        busy_next = 1'b1; state_next = LINE;
        pt_valid = 1'b1; pt_en = 1'b1;
        pt_col = erase ? BG_COLOR : ROPE_COLOR;
      end
      LINE: begin
        if (lx_reg == tx_reg && ly_reg == ty_reg) begin
          state_next = ARC_INIT;
        end else begin
          if (e2 >= dy_reg) begin err_next = err_next + dy_reg; lx_next = lx_reg + sx_reg; end
          if (e2 <= dx_reg) begin err_next = err_next + dx_reg; ly_next = ly_reg + sy_reg; end
          pt_valid = 1'b1; pt_en = 1'b1; pt_x = lx_next; pt_y = ly_next;
          pt_col = erase_reg ? BG_COLOR : ROPE_COLOR;
        end
      end
      ARC_INIT: begin
        ax_next = '0; ay_next = RAD; d_next = D0; slot_next = 3'd0;
        state_next = ARC; use_arc = 1'b1;
      end
      ARC: begin
        if (slot_reg != 3'd7) begin
          slot_next = slot_reg + 3'd1; use_arc = 1'b1;
        end else begin
          if (d_reg[CW-1]) begin
            d_next = d_reg + (ax_reg <<< 1) + THREE;
          end else begin
            d_next = d_reg + ((ax_reg - ay_reg) <<< 1) + FIVE;
            ay_next = ay_reg - ONE;
          end
          ax_next = ax_reg + ONE;
          if (ax_next <= ay_next) begin
            slot_next = 3'd0; use_arc = 1'b1;
          end else begin
            state_next = DONE; done_next = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE; busy_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
    if (use_arc) begin
      arc_pt = arc_point(slot_next, ax_next, ay_next, tx_reg, ty_reg);
      pt_x = arc_pt[2*CW-1:CW];
      pt_y = arc_pt[CW-1:0];
      pt_valid = 1'b1; pt_en = mask_reg[slot_next];
      pt_col = erase_reg ? BG_COLOR : HOOK_COLOR;
    end
    // Clipped pixels still carry their low coordinate bits.
    out_x_next = pt_valid ? pt_x[X_W-1:0] : out_x_reg;
    out_y_next = pt_valid ? pt_y[Y_W-1:0] : out_y_reg;
    color_next = pt_valid ? pt_col : color_reg;
    we_next = pt_valid && pt_en && on_screen(pt_x, pt_y);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      out_x_reg <= '0; out_y_reg <= '0; color_reg <= '0;
      we_reg <= 1'b0; busy_reg <= 1'b0; done_reg <= 1'b0;
    end else if (advance) begin
      state_reg <= state_next;
      out_x_reg <= out_x_next; out_y_reg <= out_y_next; color_reg <= color_next;
      we_reg <= we_next; busy_reg <= busy_next; done_reg <= done_next;
    end
  end

  always_ff @(posedge clock) begin
    if (advance) begin
      tx_reg <= tx_next; ty_reg <= ty_next; mask_reg <= mask_next; erase_reg <= erase_next;
      lx_reg <= lx_next; ly_reg <= ly_next; dx_reg <= dx_next; dy_reg <= dy_next;
      err_reg <= err_next; sx_reg <= sx_next; sy_reg <= sy_next;
      ax_reg <= ax_next; ay_reg <= ay_next; d_reg <= d_next; slot_reg <= slot_next;
    end
  end

  assign outX = out_x_reg;
  assign outY = out_y_reg;
  assign color = color_reg;
  assign writeEn = we_reg;
  assign busy = busy_reg;
  assign done = done_reg;
endmodule
